// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_pkg
// Brief    : State encoding and opcode constants shared by the brainfuck core.
// Revision : 1.0 - initial release
// ============================================================================
package bf_pkg;

    // Encodings double as the probe output codes.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_EXEC     = 4'd1,
        ST_SKIP_F   = 4'd2,
        ST_SKIP_E   = 4'd3,
        ST_OUT_WAIT = 4'd4,
        ST_IN_WAIT  = 4'd5,
        ST_HALT     = 4'd6,
        ST_ERROR    = 4'd7
    } bf_state_e;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;
    localparam logic [7:0] OP_HALT  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/bf_loop_stack.sv
`default_nettype none
// ============================================================================
// Module   : bf_loop_stack
// Brief    : Synchronous LIFO of loop-start addresses (push/pop/top/empty/full).
// Revision : 1.0 - initial release
// ============================================================================
module bf_loop_stack #(
    parameter int CODE_AW     = 9,
    parameter int STACK_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [CODE_AW-1:0] i_data,
    output logic [CODE_AW-1:0] o_top,
    output logic               o_empty,
    output logic               o_full
);

    localparam int c_IW = $clog2(STACK_DEPTH);

    logic [c_IW:0]        r_sp;
    logic [CODE_AW-1:0]   r_mem [STACK_DEPTH];
    logic [c_IW-1:0]      w_top_idx;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_top_idx = r_sp[c_IW-1:0] - c_IW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_sp == '0);
    assign o_full    = (r_sp == (c_IW+1)'(STACK_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + (c_IW+1)'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - (c_IW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_sp[c_IW-1:0]] <= i_data;
        end
    end

    a_no_push_pop : assert property (@(posedge clk) disable iff (rst) !(i_push && i_pop));

endmodule
`default_nettype wire

// File: rtl/bf_core_stack.sv
`default_nettype none
// ============================================================================
// Module   : bf_core_stack
// Brief    : Brainfuck execution core with hardware loop return stack and
//            valid/ready byte I/O. Define BF_PERF_COUNT_EN to add the
//            instr_count / stall_count performance outputs.
// Revision : 1.0 - initial release
// ============================================================================
module bf_core_stack
    import bf_pkg::*;
#(
    parameter int CODE_AW     = 9,
    parameter int DATA_AW     = 9,
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [CODE_AW-1:0] code_addr,
    input  logic [7:0]         code_in,
    output logic [DATA_AW-1:0] data_addr,
    input  logic [7:0]         data_rd,
    output logic [7:0]         data_wr,
    output logic               write_rq,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               halted,
    output logic               error,
    output logic [3:0]         probe
`ifdef BF_PERF_COUNT_EN
    ,
    output logic [31:0]        instr_count,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [CODE_AW-1:0] c_PC_LAST = '1;

    bf_state_e          r_state, w_state_nxt;
    logic [CODE_AW-1:0] r_pc, w_pc_nxt;
    logic [DATA_AW-1:0] r_dp, w_dp_nxt;
    logic [SKIP_W-1:0]  r_skip, w_skip_nxt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_push, w_pop;
    logic               w_out_set, w_out_clr, w_in_set, w_in_clr;
    logic [CODE_AW-1:0] w_top;
    logic               w_empty, w_full;
    logic               w_at_end;
    logic [CODE_AW-1:0] w_pc_adv;
    bf_state_e          w_adv_state;
    logic               w_out_xfer, w_in_xfer;

    bf_loop_stack #(
        .CODE_AW     (CODE_AW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // The last program byte never wraps the pc; finishing it halts the core.
    assign w_at_end    = (r_pc == c_PC_LAST);
    assign w_pc_adv    = w_at_end ? r_pc : (r_pc + CODE_AW'(1));
    assign w_adv_state = w_at_end ? ST_HALT : ST_FETCH;
    assign w_out_xfer  = r_out_valid && out_ready;
    assign w_in_xfer   = r_in_ready && in_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_dp_nxt    = r_dp;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_out_set   = 1'b0;
        w_out_clr   = 1'b0;
        w_in_set    = 1'b0;
        w_in_clr    = 1'b0;
        write_rq    = 1'b0;
        data_wr     = 8'h00;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                w_pc_nxt    = w_pc_adv;
                w_state_nxt = w_adv_state;
                case (code_in)
                    OP_INC: begin
                        write_rq = 1'b1;
                        data_wr  = data_rd + 8'd1;
                    end
                    OP_DEC: begin
                        write_rq = 1'b1;
                        data_wr  = data_rd - 8'd1;
                    end
                    OP_RIGHT: w_dp_nxt = r_dp + DATA_AW'(1);
                    OP_LEFT:  w_dp_nxt = r_dp - DATA_AW'(1);
                    OP_OUT: begin
                        w_pc_nxt    = r_pc;
                        w_out_set   = 1'b1;
                        w_state_nxt = ST_OUT_WAIT;
                    end
                    OP_IN: begin
                        w_pc_nxt    = r_pc;
                        w_in_set    = 1'b1;
                        w_state_nxt = ST_IN_WAIT;
                    end
                    OP_LOOP: begin
                        if (data_rd != 8'h00) begin
                            if (w_full) begin
                                w_pc_nxt    = r_pc;
                                w_state_nxt = ST_ERROR;
                            end else begin
                                w_push = 1'b1;
                            end
                        end else begin
                            w_skip_nxt  = SKIP_W'(1);
                            w_state_nxt = w_at_end ? ST_ERROR : ST_SKIP_F;
                        end
                    end
                    OP_END: begin
                        if (w_empty) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = ST_ERROR;
                        end else if (data_rd != 8'h00) begin
                            w_pc_nxt    = w_top + CODE_AW'(1);
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_pop = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_SKIP_F: w_state_nxt = ST_SKIP_E;
            ST_SKIP_E: begin
                // Running off the program mid-skip is an unbalanced '['.
                w_pc_nxt    = w_pc_adv;
                w_state_nxt = w_at_end ? ST_ERROR : ST_SKIP_F;
                if (code_in == OP_LOOP) begin
                    if (r_skip == '1) begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_skip_nxt = r_skip + SKIP_W'(1);
                    end
                end else if (code_in == OP_END) begin
                    w_skip_nxt = r_skip - SKIP_W'(1);
                    if (r_skip == SKIP_W'(1)) begin
                        w_state_nxt = w_adv_state;
                    end
                end
            end
            ST_OUT_WAIT: begin
                if (w_out_xfer) begin
                    w_out_clr   = 1'b1;
                    w_pc_nxt    = w_pc_adv;
                    w_state_nxt = w_adv_state;
                end
            end
            ST_IN_WAIT: begin
                if (w_in_xfer) begin
                    write_rq    = 1'b1;
                    data_wr     = in_data;
                    w_in_clr    = 1'b1;
                    w_pc_nxt    = w_pc_adv;
                    w_state_nxt = w_adv_state;
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= '0;
            r_dp        <= '0;
            r_skip      <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_dp    <= w_dp_nxt;
            r_skip  <= w_skip_nxt;
            if (w_out_set) begin
                r_out_data  <= data_rd;
                r_out_valid <= 1'b1;
            end else if (w_out_clr) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_set) begin
                r_in_ready <= 1'b1;
            end else if (w_in_clr) begin
                r_in_ready <= 1'b0;
            end
        end
    end

    assign code_addr = r_pc;
    assign data_addr = r_dp;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign halted    = (r_state == ST_HALT);
    assign error     = (r_state == ST_ERROR);
    assign probe     = r_state;

`ifdef BF_PERF_COUNT_EN
    logic [31:0] r_instr_count;
    logic [31:0] r_stall_count;
    logic        w_retire;

    // I/O opcodes retire on their handshake; faulting opcodes never retire.
    assign w_retire = ((r_state == ST_EXEC) && (w_state_nxt != ST_ERROR) &&
                       (w_state_nxt != ST_OUT_WAIT) && (w_state_nxt != ST_IN_WAIT)) ||
                      ((r_state == ST_OUT_WAIT) && w_out_xfer) ||
                      ((r_state == ST_IN_WAIT) && w_in_xfer);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_retire && (r_instr_count != '1)) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (((r_state == ST_OUT_WAIT) || (r_state == ST_IN_WAIT)) && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
